sr_cmd_conditioner: RTL and testbench

- Front-end stage that directly feeds the team's clocked SR flip-flop.
- Takes two raw, asynchronous push-button/level inputs (set request, reset request) and synchronises and debounces each one.
- Arbitrates the two and emits clean single-cycle S and R command pulses.
- Guarantees the downstream flip-flop never sees S=1 and R=1 in the same cycle; conflicts are reported instead of forwarded.

---
 rtl/sr_cmd_conditioner.sv | 170 +++++++++++++++++
 tb/tb_sr_cmd_conditioner.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: synchronises, debounces and arbitrates two raw
// push-button inputs into clean one-cycle S/R commands for the SR flip-flop.
// A simultaneous or overlapping request is reported on 'conflict' and dropped,
// so S and R are never high together.
// Optional macro SR_CMD_DB_BYPASS_EN: removes the debounce counters, so each
// debounced level simply follows its synchronised input.
module sr_cmd_conditioner #(
    parameter int DB_LIMIT = 16,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_rst,
    output logic s_pulse,
    output logic r_pulse,
    output logic set_lvl,
    output logic rst_lvl,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HELD = 2'd1,
        RST_HELD = 2'd2
    } state_t;

    logic [1:0] set_sync_q;
    logic [1:0] rst_sync_q;
    logic       sync_set;
    logic       sync_rst;

    logic       set_prev;
    logic       rst_prev;
    logic       set_rise;
    logic       rst_rise;

    state_t     state;
    state_t     state_next;
    logic       s_next;
    logic       r_next;
    logic       conf_next;

    // Two-flop synchronisers bring the asynchronous buttons into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            set_sync_q <= 2'b00;
            rst_sync_q <= 2'b00;
        end else begin
            set_sync_q <= {set_sync_q[0], btn_set};
            rst_sync_q <= {rst_sync_q[0], btn_rst};
        end
    end

    assign sync_set = set_sync_q[1];
    assign sync_rst = rst_sync_q[1];

`ifdef SR_CMD_DB_BYPASS_EN

    // Bypass build: the levels follow the synchronised inputs with no filtering
    always_ff @(posedge clk) begin
        if (rst) begin
            set_lvl <= 1'b0;
            rst_lvl <= 1'b0;
        end else begin
            set_lvl <= sync_set;
            rst_lvl <= sync_rst;
        end
    end

`else

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

    logic [CNT_W-1:0] set_cnt;
    logic [CNT_W-1:0] rst_cnt;

    // Debounce: a level only changes after DB_LIMIT consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt <= '0;
            rst_cnt <= '0;
            set_lvl <= 1'b0;
            rst_lvl <= 1'b0;
        end else begin
            if (sync_set == set_lvl) begin
                set_cnt <= '0;
            end else if (set_cnt == CNT_LAST) begin
                set_lvl <= sync_set;
                set_cnt <= '0;
            end else begin
                set_cnt <= set_cnt + 1'b1;
            end

            if (sync_rst == rst_lvl) begin
                rst_cnt <= '0;
            end else if (rst_cnt == CNT_LAST) begin
                rst_lvl <= sync_rst;
                rst_cnt <= '0;
            end else begin
                rst_cnt <= rst_cnt + 1'b1;
            end
        end
    end

`endif

    assign set_rise = set_lvl & ~set_prev;
    assign rst_rise = rst_lvl & ~rst_prev;

    // Arbitration: a rise fires a pulse only when the other side is idle
    always_comb begin
        state_next = state;
        s_next     = 1'b0;
        r_next     = 1'b0;
        conf_next  = 1'b0;
        case (state)
            IDLE: begin
                if (set_rise && rst_rise) begin
                    conf_next = 1'b1;
                end else if (set_rise) begin
                    s_next     = 1'b1;
                    state_next = SET_HELD;
                end else if (rst_rise) begin
                    r_next     = 1'b1;
                    state_next = RST_HELD;
                end
            end
            SET_HELD: begin
                if (rst_rise) begin
                    conf_next = 1'b1;
                end
                if (!set_lvl) begin
                    state_next = IDLE;
                end
            end
            RST_HELD: begin
                if (set_rise) begin
                    conf_next = 1'b1;
                end
                if (!rst_lvl) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, edge-history and registered command outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            set_prev <= 1'b0;
            rst_prev <= 1'b0;
            s_pulse  <= 1'b0;
            r_pulse  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_next;
            set_prev <= set_lvl;
            rst_prev <= rst_lvl;
            s_pulse  <= s_next;
            r_pulse  <= r_next;
            conflict <= conf_next;
        end
    end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// tb_sr_cmd_conditioner: directed, table-driven bench for sr_cmd_conditioner
// built with DB_LIMIT=4, plus hand-written multi-cycle sequences.
// When SR_CMD_DB_BYPASS_EN is defined the bypass expectations are used.
module tb_sr_cmd_conditioner;

    logic clk;
    logic rst;
    logic btn_set;
    logic btn_rst;
    logic s_pulse;
    logic r_pulse;
    logic set_lvl;
    logic rst_lvl;
    logic conflict;

    int checks;
    int failures;

    typedef struct {
        logic bs;
        logic br;
        logic exp_s;
        logic exp_r;
        logic exp_c;
        logic exp_sl;
        logic exp_rl;
    } vec_t;

    vec_t vecs[$];

    sr_cmd_conditioner #(
        .DB_LIMIT(4),
        .CNT_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_set (btn_set),
        .btn_rst (btn_rst),
        .s_pulse (s_pulse),
        .r_pulse (r_pulse),
        .set_lvl (set_lvl),
        .rst_lvl (rst_lvl),
        .conflict(conflict)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0b expected=%0b", name, actual, expected);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic bs, input logic br, input logic s, input logic r,
                          input logic c, input logic sl, input logic rl);
        vec_t v;
        v.bs = bs; v.br = br; v.exp_s = s; v.exp_r = r; v.exp_c = c;
        v.exp_sl = sl; v.exp_rl = rl;
        vecs.push_back(v);
    endtask

    // Hold inputs for n edges; each pulse output is expected only on its given edge (0 = never)
    task automatic applyStimulus(input string tag, input logic bs, input logic br, input int n,
                                 input int s_at, input int r_at, input int c_at);
        btn_set = bs;
        btn_rst = br;
        for (int k = 1; k <= n; k++) begin
            tick();
            checkOutput($sformatf("%s s_pulse edge %0d", tag, k), s_pulse, logic'(k == s_at));
            checkOutput($sformatf("%s r_pulse edge %0d", tag, k), r_pulse, logic'(k == r_at));
            checkOutput($sformatf("%s conflict edge %0d", tag, k), conflict, logic'(k == c_at));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " s_pulse"}, s_pulse, 1'b0);
        checkOutput({tag, " r_pulse"}, r_pulse, 1'b0);
        checkOutput({tag, " conflict"}, conflict, 1'b0);
        checkOutput({tag, " set_lvl"}, set_lvl, 1'b0);
        checkOutput({tag, " rst_lvl"}, rst_lvl, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        btn_set  = 1'b0;
        btn_rst  = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b0;

`ifdef SR_CMD_DB_BYPASS_EN
        // Bypass: press rst -> rst_lvl after edge 3, r_pulse after edge 4
        btn_rst = 1'b1;
        tick(); tick(); tick();
        checkOutput("byp rst_lvl edge3", rst_lvl, 1'b1);
        tick();
        checkOutput("byp r_pulse edge4", r_pulse, 1'b1);
        applyStimulus("byp hold", 1'b0, 1'b1, 4, 0, 0, 0);
        applyStimulus("byp release", 1'b0, 1'b0, 6, 0, 0, 0);
        // A single-cycle glitch is passed straight through
        applyStimulus("byp glitch", 1'b0, 1'b1, 1, 0, 0, 0);
        applyStimulus("byp glitch tail", 1'b0, 1'b0, 6, 0, 3, 0);
`else
        // Table: set press, set release, rst glitch, simultaneous press, release
        for (int j = 1; j <= 10; j++) addVec(1, 0, j == 7, 0, 0, j >= 6, 0);
        for (int j = 1; j <= 8; j++)  addVec(0, 0, 0, 0, 0, j < 6, 0);
        for (int j = 1; j <= 3; j++)  addVec(0, 1, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 9; j++)  addVec(0, 0, 0, 0, 0, 0, 0);
        for (int j = 1; j <= 10; j++) addVec(1, 1, 0, 0, j == 7, j >= 6, j >= 6);
        for (int j = 1; j <= 8; j++)  addVec(0, 0, 0, 0, 0, j < 6, j < 6);

        foreach (vecs[i]) begin
            btn_set = vecs[i].bs;
            btn_rst = vecs[i].br;
            tick();
            checkOutput($sformatf("vec%0d s_pulse", i), s_pulse, vecs[i].exp_s);
            checkOutput($sformatf("vec%0d r_pulse", i), r_pulse, vecs[i].exp_r);
            checkOutput($sformatf("vec%0d conflict", i), conflict, vecs[i].exp_c);
            checkOutput($sformatf("vec%0d set_lvl", i), set_lvl, vecs[i].exp_sl);
            checkOutput($sformatf("vec%0d rst_lvl", i), rst_lvl, vecs[i].exp_rl);
        end

        // Overlap: set held, rst pressed later is dropped, and not fired on set release
        applyStimulus("ovl set", 1'b1, 1'b0, 10, 7, 0, 0);
        applyStimulus("ovl rst", 1'b1, 1'b1, 10, 0, 0, 7);
        applyStimulus("ovl set off", 1'b0, 1'b1, 10, 0, 0, 0);
        checkOutput("ovl rst_lvl held", rst_lvl, 1'b1);
        applyStimulus("ovl rst off", 1'b0, 1'b0, 10, 0, 0, 0);
        applyStimulus("ovl rst again", 1'b0, 1'b1, 10, 0, 7, 0);
        applyStimulus("ovl rst again off", 1'b0, 1'b0, 10, 0, 0, 0);

        // Reset mid-operation with set still held: a fresh pulse 7 edges after release
        applyStimulus("rmid pre", 1'b1, 1'b0, 12, 7, 0, 0);
        rst = 1'b1;
        tick();
        checkAllZero("rmid rst1");
        tick();
        checkAllZero("rmid rst2");
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        checkOutput("rmid set_lvl edge5", set_lvl, 1'b0);
        tick();
        checkOutput("rmid set_lvl edge6", set_lvl, 1'b1);
        checkOutput("rmid s_pulse edge6", s_pulse, 1'b0);
        tick();
        checkOutput("rmid s_pulse edge7", s_pulse, 1'b1);
        tick();
        checkOutput("rmid s_pulse edge8", s_pulse, 1'b0);
        checkOutput("rmid r_pulse edge8", r_pulse, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
